// File: rtl/bp_cfg_loader.sv
// Boot-time config sequencer: writes freeze/core_id/cord to every core tile,
// unfreezes them all, waits for every write to be acknowledged, then flags done.
module bp_cfg_loader #(
  parameter int cc_x_dim_p = 1,
  parameter int cc_y_dim_p = 1,
  parameter int cc_y_offset_p = 1,
  parameter int coord_width_p = 4,
  parameter int addr_width_p = 40,
  parameter int data_width_p = 64,
  parameter logic [addr_width_p-1:0] cfg_base_addr_p = 'h0020_0000,
  parameter int max_outstanding_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  output logic                     cmd_v_o,
  input  logic                     cmd_ready_i,
  output logic [coord_width_p-1:0] cmd_x_o,
  output logic [coord_width_p-1:0] cmd_y_o,
  output logic [addr_width_p-1:0]  cmd_addr_o,
  output logic [data_width_p-1:0]  cmd_data_o,
  input  logic                     resp_v_i,
  output logic                     resp_yumi_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [2:0]               state_o
);

  localparam int num_cores_lp = cc_x_dim_p * cc_y_dim_p;
  localparam int core_w_lp = $clog2(num_cores_lp + 1);
  localparam int out_w_lp = $clog2(max_outstanding_p + 1);

  typedef enum logic [2:0] {e_reset, e_cfg, e_unfreeze, e_drain, e_done} state_e;

  state_e                   state_r;
  logic [core_w_lp-1:0]     core_cnt;
  logic [1:0]               reg_cnt;
  logic [coord_width_p-1:0] x_cnt;
  logic [coord_width_p-1:0] y_cnt;
  logic [coord_width_p-1:0] y_abs;
  logic [out_w_lp-1:0]      out_cnt;
  logic                     active;
  logic                     hs;
  logic                     last_core;
  logic                     core_step;

  // Handshake: a command transfers on any cycle where cmd_v_o & cmd_ready_i;
  // once cmd_v_o is high every cmd_* field holds until that cycle.
  assign active      = (state_r == e_cfg) || (state_r == e_unfreeze);
  assign cmd_v_o     = active && (out_cnt < out_w_lp'(max_outstanding_p));
  assign hs          = cmd_v_o & cmd_ready_i;
  assign last_core   = (core_cnt == core_w_lp'(num_cores_lp - 1));
  assign core_step   = hs && ((state_r == e_unfreeze) || (reg_cnt == 2'd2));
  assign resp_yumi_o = resp_v_i;
  assign state_o     = state_r;
  assign y_abs       = y_cnt + coord_width_p'(cc_y_offset_p);

  // Fields are pure functions of registered counters, so they only move on a handshake.
  always_comb begin
    cmd_x_o    = '0;
    cmd_y_o    = '0;
    cmd_addr_o = '0;
    cmd_data_o = '0;
    if (active) begin
      cmd_x_o    = x_cnt;
      cmd_y_o    = y_abs;
      cmd_addr_o = cfg_base_addr_p;
      if (state_r == e_cfg) begin
        case (reg_cnt)
          2'd0: cmd_data_o = data_width_p'(1);
          2'd1: begin
            cmd_addr_o = cfg_base_addr_p + addr_width_p'(8);
            cmd_data_o = data_width_p'(core_cnt);
          end
          default: begin
            cmd_addr_o = cfg_base_addr_p + addr_width_p'(16);
            cmd_data_o = data_width_p'({y_abs, x_cnt});
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= e_reset;
      core_cnt <= '0;
      reg_cnt  <= '0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      out_cnt  <= '0;
      done_o   <= 1'b0;
      error_o  <= 1'b0;
    end else begin
      // An ack with nothing in flight is bogus: flag it and do not count it.
      if (resp_v_i && (out_cnt == '0)) begin
        error_o <= 1'b1;
        out_cnt <= out_cnt + out_w_lp'(hs);
      end else begin
        out_cnt <= out_cnt + out_w_lp'(hs) - out_w_lp'(resp_v_i);
      end

      done_o <= done_o | (state_r == e_done);

      if (hs && (state_r == e_cfg))
        reg_cnt <= (reg_cnt == 2'd2) ? 2'd0 : reg_cnt + 2'd1;

      if (core_step) begin
        if (last_core) begin
          core_cnt <= '0;
          x_cnt    <= '0;
          y_cnt    <= '0;
        end else begin
          core_cnt <= core_cnt + core_w_lp'(1);
          if (x_cnt == coord_width_p'(cc_x_dim_p - 1)) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + coord_width_p'(1);
          end else begin
            x_cnt <= x_cnt + coord_width_p'(1);
          end
        end
      end

      case (state_r)
        e_reset:    state_r <= e_cfg;
        e_cfg:      if (core_step && last_core) state_r <= e_unfreeze;
        e_unfreeze: if (core_step && last_core) state_r <= e_drain;
        e_drain:    if (out_cnt == '0) state_r <= e_done;
        default:    state_r <= state_r;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Bench for bp_cfg_loader: directed 1x1 sequence plus a 2x2 instance checked
// every cycle against a command-list / credit reference model.
module tb_bp_cfg_loader;

  localparam int CW = 4;
  localparam int AW = 40;
  localparam int DW = 64;
  localparam int MO = 4;
  localparam int XD = 2;
  localparam int YD = 2;
  localparam int YO = 1;
  localparam int N  = XD * YD;
  localparam logic [AW-1:0] BASE = 40'h20_0000;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // 2x2 instance
  logic          cmd_v, cmd_ready, resp_v, resp_yumi, done, error;
  logic [CW-1:0] cmd_x, cmd_y;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [2:0]    state;

  // 1x1 instance
  logic          one_v, one_ready, one_resp, one_yumi, one_done, one_error;
  logic [CW-1:0] one_x, one_y;
  logic [AW-1:0] one_addr;
  logic [DW-1:0] one_data;
  logic [2:0]    one_state;

  bp_cfg_loader #(.cc_x_dim_p(XD), .cc_y_dim_p(YD), .cc_y_offset_p(YO), .coord_width_p(CW),
                  .addr_width_p(AW), .data_width_p(DW), .cfg_base_addr_p(BASE),
                  .max_outstanding_p(MO)) u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .cmd_v_o(cmd_v), .cmd_ready_i(cmd_ready),
    .cmd_x_o(cmd_x), .cmd_y_o(cmd_y), .cmd_addr_o(cmd_addr), .cmd_data_o(cmd_data),
    .resp_v_i(resp_v), .resp_yumi_o(resp_yumi), .done_o(done), .error_o(error),
    .state_o(state));

  bp_cfg_loader #(.cc_x_dim_p(1), .cc_y_dim_p(1), .cc_y_offset_p(1), .coord_width_p(CW),
                  .addr_width_p(AW), .data_width_p(DW), .cfg_base_addr_p(BASE),
                  .max_outstanding_p(MO)) u_one (
    .clk_i(clk), .reset_n_i(reset_n), .cmd_v_o(one_v), .cmd_ready_i(one_ready),
    .cmd_x_o(one_x), .cmd_y_o(one_y), .cmd_addr_o(one_addr), .cmd_data_o(one_data),
    .resp_v_i(one_resp), .resp_yumi_o(one_yumi), .done_o(one_done), .error_o(one_error),
    .state_o(one_state));

  // scoreboard and reference model
  int   checks = 0;
  int   errors = 0;
  cmd_t exp_q[$];
  int   out_m;
  bit   err_m, started_m, all_m, done_state_m, done_m;
  int   hs_dut;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cmd_t c;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      c.x = CW'(k % XD);
      c.y = CW'(k / XD + YO);
      c.addr = BASE;        c.data = 64'd1;                           exp_q.push_back(c);
      c.addr = BASE + 40'h8;  c.data = DW'(k);                        exp_q.push_back(c);
      c.addr = BASE + 40'h10; c.data = DW'((32'(k / XD + YO) << CW) | 32'(k % XD)); exp_q.push_back(c);
    end
    for (int k = 0; k < N; k++) begin
      c.x = CW'(k % XD);
      c.y = CW'(k / XD + YO);
      c.addr = BASE; c.data = '0;
      exp_q.push_back(c);
    end
    out_m = 0; err_m = 0; started_m = 0; all_m = 0; done_state_m = 0; done_m = 0;
    hs_dut = 0;
  endtask

  // Called at a negedge with inputs already driven; checks, then advances one clock.
  task automatic tick();
    bit   v_exp, hs, all_pre;
    int   out_pre;
    cmd_t obs;
    v_exp = started_m && (exp_q.size() > 0) && (out_m < MO);
    check_eq("cmd_v", cmd_v, v_exp);
    check_eq("error", error, err_m);
    check_eq("done", done, done_m);
    check_eq("resp_yumi", resp_yumi, resp_v);
    if (v_exp) begin
      obs = {cmd_x, cmd_y, cmd_addr, cmd_data};
      check_eq("cmd_fields", obs, exp_q[0]);
    end
    if (cmd_v && cmd_ready) hs_dut++;
    hs = v_exp && cmd_ready;
    all_pre = all_m;
    out_pre = out_m;
    @(posedge clk);
    done_m = done_m | done_state_m;
    if (all_pre && out_pre == 0) done_state_m = 1;
    if (resp_v && out_m == 0) begin
      err_m = 1;
      out_m = out_m + int'(hs);
    end else begin
      out_m = out_m + int'(hs) - int'(resp_v);
    end
    if (hs) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) all_m = 1;
    end
    started_m = 1;
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_v"}, cmd_v, 1'b0);
    check_eq({tag, "_fields"}, {cmd_x, cmd_y, cmd_addr, cmd_data}, '0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_error"}, error, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    cmd_ready = 1'b0; resp_v = 1'b0; one_ready = 1'b1; one_resp = 1'b0;
    #3;
    check_outputs_zero("reset");
    check_eq("reset_one_v", one_v, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic run_random(input int left, input bit to_done);
    int budget = 3000;
    while (budget > 0 && (to_done ? !done_m : (exp_q.size() > left))) begin
      cmd_ready = ($urandom_range(0, 3) != 0);
      resp_v = (out_m > 0) && ($urandom_range(0, 2) == 0);
      tick();
      budget--;
    end
    cmd_ready = 1'b0; resp_v = 1'b0;
    check_eq("run_budget", budget > 0, 1'b1);
  endtask

  initial begin
    cmd_t one_tbl[4];
    cmd_t obs;
    int   n1, r1, r4_at, done_at;
    logic pend;

    cmd_ready = 1'b0; resp_v = 1'b0; one_ready = 1'b1; one_resp = 1'b0;
    one_tbl[0] = '{x: 4'd0, y: 4'd1, addr: 40'h20_0000, data: 64'h1};
    one_tbl[1] = '{x: 4'd0, y: 4'd1, addr: 40'h20_0008, data: 64'h0};
    one_tbl[2] = '{x: 4'd0, y: 4'd1, addr: 40'h20_0010, data: 64'h10};
    one_tbl[3] = '{x: 4'd0, y: 4'd1, addr: 40'h20_0000, data: 64'h0};
    #12;

    // 1x1: always ready, each ack one cycle after its command
    do_reset();
    n1 = 0; r1 = 0; r4_at = -1; done_at = -1; pend = 1'b0;
    for (int c = 0; c < 30; c++) begin
      one_resp = pend;
      if (pend) begin
        r1++;
        if (r1 == 4) r4_at = c;
      end
      pend = one_v;
      if (one_v) begin
        obs = {one_x, one_y, one_addr, one_data};
        if (n1 < 4) check_eq("one_cmd", obs, one_tbl[n1]);
        n1++;
      end
      if (one_done && done_at < 0) done_at = c;
      @(negedge clk);
    end
    one_resp = 1'b0;
    check_eq("one_cmd_count", n1, 4);
    check_eq("one_done_latency", done_at - r4_at, 3);
    check_eq("one_error", one_error, 1'b0);

    // ack with nothing outstanding
    do_reset();
    resp_v = 1'b1;
    tick();
    resp_v = 1'b0;
    repeat (3) tick();
    check_eq("err_out_cnt", u_dut.out_cnt, 3'(out_m));

    // acks withheld: credit limit, one ack frees one slot, backpressure hold
    do_reset();
    cmd_ready = 1'b1;
    repeat (10) tick();
    check_eq("hs_withheld", hs_dut, 4);
    cmd_ready = 1'b0; resp_v = 1'b1;
    tick();
    resp_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", cmd_v, 1'b1);
      check_eq("bp_fields", {cmd_x, cmd_y, cmd_addr, cmd_data}, {4'd1, 4'd1, 40'h20_0008, 64'd1});
      tick();
    end
    cmd_ready = 1'b1;
    repeat (4) tick();
    check_eq("hs_one_more", hs_dut, 5);
    cmd_ready = 1'b0; resp_v = 1'b1;
    repeat (2) tick();
    cmd_ready = 1'b1;
    tick();
    resp_v = 1'b0; cmd_ready = 1'b0;
    check_eq("out_cnt_simul", u_dut.out_cnt, 3'd2);
    run_random(0, 1'b1);
    check_eq("hs_total", hs_dut, 4 * N);
    check_eq("done_final", done, 1'b1);
    check_eq("error_final", error, 1'b0);

    // reset pulse in the middle of the unfreeze phase
    do_reset();
    run_random(2, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cmd_ready = 1'b1; resp_v = 1'b1;
    tick();
    resp_v = 1'b0;
    check_eq("restart_first_v", cmd_v, 1'b1);
    check_eq("restart_first", {cmd_x, cmd_y, cmd_addr, cmd_data}, {4'd0, 4'd1, 40'h20_0000, 64'd1});
    run_random(0, 1'b1);
    check_eq("restart_hs_total", hs_dut, 4 * N);
    check_eq("restart_done", done, 1'b1);
    check_eq("stale_error", error, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
